// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, default line
// rates and the clocks-per-bit computation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 9600;

   function automatic int calc_bit_cyc(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line reads as idle out of reset.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register, frame error pulse and
// sticky overrun. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
//
// state | meaning
// IDLE  | line idle, waiting for a 1->0 edge on the synchronized line
// START | timing to the start-bit midpoint; a high sample rejects the glitch
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit; 1 loads the byte, 0 pulses frame_err
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       read_en,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int BIT_CYC  = calc_bit_cyc(CLK_FREQ, BAUD);
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CNT_W    = $clog2(BIT_CYC);

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);

   logic rx_s;
   logic rx_prev;
   logic sample;

   uart_sync #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (rx),
      .q  (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Majority decisions land one cycle after the nominal target so the
   // target+1 sample exists; every later decision inherits the same offset.
   localparam logic [CNT_W-1:0] START_TGT = CNT_W'(HALF_CYC);

   logic [1:0] rx_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_hist <= 2'b11;
      else     rx_hist <= {rx_hist[0], rx_s};
   end

   assign rx_prev = rx_hist[0];
   assign sample  = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) |
                    (rx_hist[0] & rx_s);
`else
   localparam logic [CNT_W-1:0] START_TGT = CNT_W'(HALF_CYC - 1);

   logic rx_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_hist <= 1'b1;
      else     rx_hist <= rx_s;
   end

   assign rx_prev = rx_hist;
   assign sample  = rx_s;
`endif

   uart_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (read_en && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_cnt <= '0;
               if (rx_prev && !rx_s) state <= START;
            end
            START: begin
               if (cnt == START_TGT) begin
                  cnt   <= '0;
                  state <= sample ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt       <= '0;
                  shift_reg <= {sample, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (sample) begin
                     data       <= shift_reg;
                     data_valid <= 1'b1;
                     // A same-cycle read frees the holder, so nothing is lost.
                     if (data_valid && !read_en) overrun <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, with randomized frames
// compared against a frame-level model of the holding register and flags.
module tb_uart_rx;

   localparam int BITC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       read_en;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int ferr_cycles = 0;

   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ovr;
   int         m_ferr;

   uart_rx #(
      .CLK_FREQ(16),
      .BAUD    (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .read_en   (read_en),
      .data      (data),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err === 1'b1) ferr_cycles++;

   function automatic logic line_val(input logic [7:0] b, input logic stop,
                                     input int c, input int glitch_bit);
      int k;
      k = c / BITC;
      if (glitch_bit >= 0 && c == BITC * (glitch_bit + 1) + BITC / 2) return 1'b0;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return stop;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one full 10-bit frame; optional single-cycle glitch at a data-bit
   // midpoint and optional read_en landing on the stop-sample decision cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int glitch_bit, input bit read_same);
      for (int c = 0; c < 10 * BITC; c++) begin
         @(posedge clk);
         #1;
         rx = line_val(b, stop, c, glitch_bit);
         if (read_same) read_en = (c == 9 * BITC + BITC / 2 + 2);
      end
      read_en = 1'b0;
      if (!stop) begin
         @(posedge clk);
         #1;
         rx = 1'b1;
         idle(4);
      end
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stop, input bit read_same);
      if (read_same && m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      if (stop) begin
         if (m_valid) m_ovr = 1'b1;
         m_data  = b;
         m_valid = 1'b1;
      end else begin
         m_ferr++;
      end
   endtask

   task automatic do_read();
      @(posedge clk);
      #1;
      read_en = 1'b1;
      @(posedge clk);
      #1;
      read_en = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic test_reset();
      checks++;
      if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", data_valid); end
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_good_frame();
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      model_frame(8'hA5, 1'b1, 1'b0);
      checks++;
      if (data !== 8'hA5) begin errors++; $display("FAIL good_data got %h exp a5", data); end
      checks++;
      if (data_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b exp 1", data_valid); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL good_ovr got %b exp 0", overrun); end
      checks++;
      if (ferr_cycles !== m_ferr) begin errors++; $display("FAIL good_ferr got %0d exp %0d", ferr_cycles, m_ferr); end
      do_read();
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL good_read_valid got %b exp 0", data_valid); end
      do_read();
      checks++;
      if (data !== 8'hA5 || data_valid !== 1'b0) begin
         errors++; $display("FAIL idle_read got %h/%b exp a5/0", data, data_valid);
      end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, -1, 1'b0);
      model_frame(8'h3C, 1'b0, 1'b0);
      checks++;
      if (ferr_cycles !== m_ferr) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", ferr_cycles, m_ferr); end
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b exp 0", data_valid); end
      checks++;
      if (data !== m_data) begin errors++; $display("FAIL ferr_data got %h exp %h", data, m_data); end
   endtask

   task automatic test_start_glitch();
      @(posedge clk);
      #1;
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(40);
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b exp 0", data_valid); end
      checks++;
      if (ferr_cycles !== m_ferr) begin errors++; $display("FAIL glitch_ferr got %0d exp %0d", ferr_cycles, m_ferr); end
      send_frame(8'h96, 1'b1, -1, 1'b0);
      model_frame(8'h96, 1'b1, 1'b0);
      checks++;
      if (data !== m_data) begin errors++; $display("FAIL glitch_next got %h exp %h", data, m_data); end
      do_read();
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b1, -1, 1'b0);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      model_frame(8'h22, 1'b1, 1'b0);
      checks++;
      if (data !== 8'h22) begin errors++; $display("FAIL ovr_data got %h exp 22", data); end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
      checks++;
      if (data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", data_valid); end
      do_read();
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_read_valid got %b exp 0", data_valid); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_read_flag got %b exp 0", overrun); end
   endtask

   task automatic test_read_same_cycle();
      send_frame(8'h33, 1'b1, -1, 1'b0);
      model_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, -1, 1'b0);
      model_frame(8'h44, 1'b1, 1'b0);
      send_frame(8'h55, 1'b1, -1, 1'b1);
      model_frame(8'h55, 1'b1, 1'b1);
      checks++;
      if (data !== 8'h55) begin errors++; $display("FAIL same_data got %h exp 55", data); end
      checks++;
      if (data_valid !== 1'b1) begin errors++; $display("FAIL same_valid got %b exp 1", data_valid); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL same_ovr got %b exp 0", overrun); end
      do_read();
   endtask

   task automatic test_majority_glitch();
      int         gb;
      logic [7:0] exp_b;
      logic [7:0] one;
      gb  = int'($urandom_range(0, 7));
      one = 8'h01;
`ifdef UART_RX_MAJORITY_EN
      exp_b = 8'hFF;
`else
      exp_b = 8'hFF & ~(one << gb);
`endif
      send_frame(8'hFF, 1'b1, gb, 1'b0);
      model_frame(exp_b, 1'b1, 1'b0);
      checks++;
      if (data !== exp_b) begin errors++; $display("FAIL maj_glitch bit %0d got %h exp %h", gb, data, exp_b); end
      do_read();
   endtask

   task automatic test_reset_mid();
      send_frame(8'h77, 1'b1, -1, 1'b0);
      model_frame(8'h77, 1'b1, 1'b0);
      for (int c = 0; c < 5 * BITC + BITC / 2; c++) begin
         @(posedge clk);
         #1;
         rx = line_val(8'hFF, 1'b1, c, -1);
      end
      rst = 1'b1;
      rx  = 1'b1;
      idle(2);
      rst = 1'b0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      idle(2 * BITC);
      checks++;
      if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", data); end
      checks++;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", data_valid); end
      checks++;
      if (ferr_cycles !== m_ferr) begin errors++; $display("FAIL rstmid_ferr got %0d exp %0d", ferr_cycles, m_ferr); end
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      model_frame(8'h5A, 1'b1, 1'b0);
      checks++;
      if (data !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data got %h exp 5a", data); end
      checks++;
      if (data_valid !== 1'b1 || overrun !== 1'b0) begin
         errors++; $display("FAIL rstmid_next_flags got v%b o%b exp v1 o0", data_valid, overrun);
      end
      checks++;
      if (ferr_cycles !== m_ferr) begin errors++; $display("FAIL rstmid_next_ferr got %0d exp %0d", ferr_cycles, m_ferr); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       stop;
      int         mode;
      for (int i = 0; i < 12; i++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         mode = int'($urandom_range(0, 2));
         if (mode == 1) do_read();
         send_frame(b, stop, -1, mode == 2);
         model_frame(b, stop, mode == 2);
         checks++;
         if (data !== m_data) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", i, data, m_data); end
         checks++;
         if (data_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_valid got %b exp %b", i, data_valid, m_valid); end
         checks++;
         if (overrun !== m_ovr) begin errors++; $display("FAIL rnd%0d_ovr got %b exp %b", i, overrun, m_ovr); end
         checks++;
         if (ferr_cycles !== m_ferr) begin errors++; $display("FAIL rnd%0d_ferr got %0d exp %0d", i, ferr_cycles, m_ferr); end
      end
   endtask

   initial begin
      rst     = 1'b1;
      rx      = 1'b1;
      read_en = 1'b0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 0;
      idle(3);
      test_reset();
      test_good_frame();
      test_frame_err();
      test_start_glitch();
      test_overrun();
      test_read_same_cycle();
      test_majority_glitch();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
